ctrl_unit_mc: RTL and testbench
===============================

Name: ctrl_unit_mc

Overview:
- Parametrised multicycle MIPS control FSM; successor to the single-instruction (add-only) control unit.
- Sequences fetch / decode / execute / memory / writeback for the datapath's PC, IR, register file, A/B, ALUOut, MDR and EPC.
- Adds configurable memory wait states and decode length, a wider instruction set, PC-source control and overflow / invalid-opcode exceptions.

Parameters:
MEM_WAIT, 2, wait cycles before memory data is valid (>=1); applies to fetch and lw read.
DEC_CYCLES, 2, decode length in cycles (>=2).
EXC_EN, 1, 1 = overflow / invalid-opcode trap enabled; 0 = overflow ignored and invalid opcode treated as nop.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
Overflow  in  1  ALU overflow
Zero  in  1  ALU zero
EQ  in  1  A==B compare
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
pc_w, mem_w, ir_w, reg_w, reg_ab_w, aluOut_w, mdr_w, epc_w, hi_w, lo_w  out  1 each  write enables
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
reg_dst  out  2  00 = rt, 01 = rd, 10 = $31, 11 = $29
data_src  out  3  000 = ALUOut, 001 = MDR, others reserved
alu_op  out  3  000 = pass A, 001 = add, 010 = sub, 011 = and
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector
mem_addr_src  out  1  0 = PC, 1 = ALUOut
exc_cause  out  1  0 = overflow, 1 = invalid opcode; valid while epc_w=1
rst_out  out  1  datapath reset
state_dbg  out  4  current state encoding

Behaviour:
- Moore machine. Outputs decode only from the state and counter registers; there is no combinational input-to-output path. Values below are valid during the listed cycle. Any output not listed is 0 (alu_op=001).
- reset: reset==0 at a rising edge loads state RESET and counter 0. While in RESET: all write enables 0, rst_out=1, selects 0. A reset asserted mid-instruction aborts it; no write enable may be high in the following cycle.
- RESET (1 cycle after reset==1): rst_out=1 -> FETCH.
- FETCH (MEM_WAIT+1 cycles):
  - counter < MEM_WAIT: alu_src_a=0, alu_src_b=01, alu_op=001.
  - Last cycle: same selects plus pc_w=1, ir_w=1, pc_src=00 -> DECODE; counter cleared.
- DECODE, cycle 0: reg_ab_w=1, aluOut_w=1, alu_src_a=0, alu_src_b=11, alu_op=001 (branch target).
- DECODE, final cycle (DEC_CYCLES-1): dispatch.
  - R (000000): funct 100000 add / 100010 sub / 100100 and -> EXEC_R.
  - addi (001000) -> EXEC_I.
  - lw (100011), sw (101011) -> MEM_ADDR.
  - beq (000100), bne (000101) -> BRANCH.
  - j (000010) -> JUMP.
  - Anything else -> EXC (cause 1) if EXC_EN, else CLOSE.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct, aluOut_w=1. If Overflow and add/sub and EXC_EN -> EXC (cause 0); else -> WB_R.
- WB_R: reg_w=1, reg_dst=01, data_src=000 -> CLOSE.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=001, aluOut_w=1. Overflow handling as EXEC_R; otherwise -> WB_I.
- WB_I: reg_w=1, reg_dst=00, data_src=000 -> CLOSE.
- MEM_ADDR: EXEC_I selects, aluOut_w=1, no overflow check.
  - lw -> MEM_RD.
  - sw -> MEM_WR.
- MEM_RD (MEM_WAIT+1 cycles): mem_addr_src=1 throughout; mdr_w=1 on the last cycle only -> MEM_WB.
- MEM_WB: reg_w=1, reg_dst=00, data_src=001 -> CLOSE.
- MEM_WR: mem_w=1, mem_addr_src=1, one cycle -> CLOSE.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=010, pc_src=01. pc_w = EQ for beq, !EQ for bne -> CLOSE.
- JUMP: pc_w=1, pc_src=10 -> CLOSE.
- EXC, 2 cycles:
  - c0: epc_w=1, alu_src_a=0, alu_src_b=01, alu_op=010 (EPC <= PC-4), exc_cause valid.
  - c1: pc_w=1, pc_src=11 -> CLOSE.
  - No reg_w or mem_w anywhere on the exception path.
- CLOSE: all write enables 0 -> FETCH.
- counter: 3 bits, cleared on every state change, saturates (never wraps) within a state. Every write enable is a single-cycle pulse.

Test Plan:
- Defaults; reset low 2 cycles, then high; add in IR -> RESET cycle 1, FETCH 2-4 (pc_w/ir_w in 4), DECODE 5-6, EXEC_R 7, reg_w=1 with reg_dst=01 in 8, CLOSE 9, FETCH 10.
- MEM_WAIT=4, lw -> FETCH 5 cycles, MEM_RD 5 cycles with mdr_w only in its last cycle, then reg_w with data_src=001.
- sw -> exactly one mem_w pulse with mem_addr_src=1; reg_w never asserted.
- beq with EQ=1 -> pc_w=1, pc_src=01 in BRANCH. beq with EQ=0 -> no pc_w. bne inverts both cases.
- add with Overflow=1 in EXEC_R -> epc_w=1, exc_cause=0, then pc_w with pc_src=11; no reg_w. Opcode 111111 -> same sequence with exc_cause=1. With EXC_EN=0 the same stimuli write back (add) or go straight to CLOSE (bad opcode).
- reset driven low during MEM_RD -> next cycle state_dbg=RESET, all write enables 0, rst_out=1.

Source files
------------

// File: rtl/ctrl_unit_mc_if.sv
// ctrl_unit_mc_if: status/opcode inputs and write-enable/select outputs between
// the multicycle MIPS control unit (master) and its datapath (slave).
interface ctrl_unit_mc_if;
    logic       Overflow, Zero, EQ;
    logic [5:0] opcode, funct;
    logic       pc_w, mem_w, ir_w, reg_w, reg_ab_w, aluOut_w, mdr_w, epc_w, hi_w, lo_w;
    logic       alu_src_a;
    logic [1:0] alu_src_b, reg_dst, pc_src;
    logic [2:0] data_src, alu_op;
    logic       mem_addr_src, exc_cause, rst_out;
    logic [3:0] state_dbg;
    modport master(
        input  Overflow, Zero, EQ, opcode, funct,
        output pc_w, mem_w, ir_w, reg_w, reg_ab_w, aluOut_w, mdr_w, epc_w, hi_w, lo_w,
        output alu_src_a, alu_src_b, reg_dst, data_src, alu_op, pc_src,
        output mem_addr_src, exc_cause, rst_out, state_dbg
    );
    modport slave(
        output Overflow, Zero, EQ, opcode, funct,
        input  pc_w, mem_w, ir_w, reg_w, reg_ab_w, aluOut_w, mdr_w, epc_w, hi_w, lo_w,
        input  alu_src_a, alu_src_b, reg_dst, data_src, alu_op, pc_src,
        input  mem_addr_src, exc_cause, rst_out, state_dbg
    );
endinterface

// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: Moore multicycle MIPS control FSM with memory wait states,
// configurable decode length and overflow / invalid-opcode traps.
module ctrl_unit_mc #(
    parameter int MEM_WAIT   = 2,
    parameter int DEC_CYCLES = 2,
    parameter int EXC_EN     = 1
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_unit_mc_if.master bus
);
    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_EXC, S_CLOSE
    } state_t;
    localparam logic [2:0] MEM_LAST = 3'(MEM_WAIT);
    localparam logic [2:0] DEC_LAST = 3'(DEC_CYCLES - 1);
    localparam logic       TRAP     = (EXC_EN != 0);
    state_t     r_state, w_next, w_disp;
    logic [2:0] r_cnt, r_alu;
    logic       r_take, r_lw, r_arith, r_cause;
    always_comb begin
        w_disp = TRAP ? S_EXC : S_CLOSE;
        case (bus.opcode)
            6'b000000: if (bus.funct inside {6'b100000, 6'b100010, 6'b100100}) w_disp = S_EXEC_R;
            6'b001000: w_disp = S_EXEC_I;
            6'b100011, 6'b101011: w_disp = S_MEM_ADDR;
            6'b000100, 6'b000101: w_disp = S_BRANCH;
            6'b000010: w_disp = S_JUMP;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 3'd0 : (r_cnt == 3'd7 ? r_cnt : r_cnt + 3'd1);
        end
    end
    // A/B are loaded in decode cycle 0, so EQ is settled by the final decode cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_DECODE && r_cnt == DEC_LAST) begin
            r_take  <= (bus.opcode == 6'b000100) ? bus.EQ : !bus.EQ;
            r_lw    <= (bus.opcode == 6'b100011);
            r_arith <= (bus.funct != 6'b100100);
            r_alu   <= (bus.funct == 6'b100010) ? 3'b010 : (bus.funct == 6'b100100) ? 3'b011 : 3'b001;
        end
        if (w_next == S_EXC && r_state != S_EXC)
            r_cause <= (r_state == S_DECODE);
    end
    always_comb begin
        w_next           = r_state;
        bus.pc_w         = 1'b0;
        bus.mem_w        = 1'b0;
        bus.ir_w         = 1'b0;
        bus.reg_w        = 1'b0;
        bus.reg_ab_w     = 1'b0;
        bus.aluOut_w     = 1'b0;
        bus.mdr_w        = 1'b0;
        bus.epc_w        = 1'b0;
        bus.hi_w         = 1'b0;
        bus.lo_w         = 1'b0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'b00;
        bus.reg_dst      = 2'b00;
        bus.data_src     = 3'b000;
        bus.alu_op       = 3'b001;
        bus.pc_src       = 2'b00;
        bus.mem_addr_src = 1'b0;
        bus.exc_cause    = 1'b0;
        bus.rst_out      = 1'b0;
        bus.state_dbg    = r_state;
        case (r_state)
            S_RESET: begin
                bus.rst_out = 1'b1;
                w_next      = S_FETCH;
            end
            S_FETCH: begin
                bus.alu_src_b = 2'b01;
                if (r_cnt == MEM_LAST) begin
                    bus.pc_w = 1'b1;
                    bus.ir_w = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_cnt == 3'd0) begin
                    bus.reg_ab_w  = 1'b1;
                    bus.aluOut_w  = 1'b1;
                    bus.alu_src_b = 2'b11;
                end
                if (r_cnt == DEC_LAST) w_next = w_disp;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = r_alu;
                bus.aluOut_w  = 1'b1;
                w_next        = (bus.Overflow && r_arith && TRAP) ? S_EXC : S_WB_R;
            end
            S_WB_R: begin
                bus.reg_w   = 1'b1;
                bus.reg_dst = 2'b01;
                w_next      = S_CLOSE;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.aluOut_w  = 1'b1;
                w_next        = (r_state == S_MEM_ADDR) ? (r_lw ? S_MEM_RD : S_MEM_WR) :
                                (bus.Overflow && TRAP) ? S_EXC : S_WB_I;
            end
            S_WB_I: begin
                bus.reg_w = 1'b1;
                w_next    = S_CLOSE;
            end
            S_MEM_RD: begin
                bus.mem_addr_src = 1'b1;
                if (r_cnt == MEM_LAST) begin
                    bus.mdr_w = 1'b1;
                    w_next    = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                bus.reg_w    = 1'b1;
                bus.data_src = 3'b001;
                w_next       = S_CLOSE;
            end
            S_MEM_WR: begin
                bus.mem_w        = 1'b1;
                bus.mem_addr_src = 1'b1;
                w_next           = S_CLOSE;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 3'b010;
                bus.pc_src    = 2'b01;
                bus.pc_w      = r_take;
                w_next        = S_CLOSE;
            end
            S_JUMP: begin
                bus.pc_w   = 1'b1;
                bus.pc_src = 2'b10;
                w_next     = S_CLOSE;
            end
            S_EXC: begin
                if (r_cnt == 3'd0) begin
                    bus.epc_w     = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = 3'b010;
                    bus.exc_cause = r_cause;
                end else begin
                    bus.pc_w   = 1'b1;
                    bus.pc_src = 2'b11;
                    w_next     = S_CLOSE;
                end
            end
            S_CLOSE: w_next = S_FETCH;
            default: w_next = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// tb_ctrl_unit_mc: directed vectors for ctrl_unit_mc; three instances cover the
// default build, MEM_WAIT=4 and EXC_EN=0.
module tb_ctrl_unit_mc;
    localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_WB_R = 4;
    localparam int S_MEM_RD = 8, S_CLOSE = 14;
    typedef struct packed {
        logic [3:0] st;
        logic [9:0] we;
        logic       src_a;
        logic [1:0] src_b, reg_dst;
        logic [2:0] data_src, alu_op;
        logic [1:0] pc_src;
        logic       addr_src, cause, rst_out;
    } obs_t;
    typedef struct {
        logic [5:0] op, fn;
        logic       eq, ov;
        int         cyc, pc, rg, mem, mdr, epc, cause, lpcs, wb;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, EQ = 1'b0, Overflow = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    int sel = 0, total = 0, bad = 0;
    int cyc, n_pc, n_reg, n_mem, n_mdr, n_epc, cause, lpcs, wb, n_fetch, n_memrd, mdr_at, bad_addr, done;
    obs_t o0, o1, o2, o;
    vec_t tv[14];
    int exp_st[10] = '{0, 1, 1, 1, 2, 2, 3, 4, 14, 1};
    int exp_we[10] = '{0, 0, 0, 'h280, 'h030, 0, 'h010, 'h040, 0, 0};

    always #5 clk = ~clk;

    ctrl_unit_mc_if if0(), if1(), if2();
    assign {if0.Overflow, if0.Zero, if0.EQ, if0.opcode, if0.funct} = {Overflow, 1'b0, EQ, opcode, funct};
    assign {if1.Overflow, if1.Zero, if1.EQ, if1.opcode, if1.funct} = {Overflow, 1'b0, EQ, opcode, funct};
    assign {if2.Overflow, if2.Zero, if2.EQ, if2.opcode, if2.funct} = {Overflow, 1'b0, EQ, opcode, funct};
    ctrl_unit_mc dut0(.clk(clk), .reset(reset), .bus(if0));
    ctrl_unit_mc #(.MEM_WAIT(4)) dut1(.clk(clk), .reset(reset), .bus(if1));
    ctrl_unit_mc #(.EXC_EN(0)) dut2(.clk(clk), .reset(reset), .bus(if2));

    assign o0 = {if0.state_dbg, if0.pc_w, if0.mem_w, if0.ir_w, if0.reg_w, if0.reg_ab_w, if0.aluOut_w,
                 if0.mdr_w, if0.epc_w, if0.hi_w, if0.lo_w, if0.alu_src_a, if0.alu_src_b, if0.reg_dst,
                 if0.data_src, if0.alu_op, if0.pc_src, if0.mem_addr_src, if0.exc_cause, if0.rst_out};
    assign o1 = {if1.state_dbg, if1.pc_w, if1.mem_w, if1.ir_w, if1.reg_w, if1.reg_ab_w, if1.aluOut_w,
                 if1.mdr_w, if1.epc_w, if1.hi_w, if1.lo_w, if1.alu_src_a, if1.alu_src_b, if1.reg_dst,
                 if1.data_src, if1.alu_op, if1.pc_src, if1.mem_addr_src, if1.exc_cause, if1.rst_out};
    assign o2 = {if2.state_dbg, if2.pc_w, if2.mem_w, if2.ir_w, if2.reg_w, if2.reg_ab_w, if2.aluOut_w,
                 if2.mdr_w, if2.epc_w, if2.hi_w, if2.lo_w, if2.alu_src_a, if2.alu_src_b, if2.reg_dst,
                 if2.data_src, if2.alu_op, if2.pc_src, if2.mem_addr_src, if2.exc_cause, if2.rst_out};
    always_comb o = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Entered at a negedge in the first FETCH cycle; returns at the next one.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic ov);
        bit seen = 1'b0;
        opcode = op; funct = fn; EQ = eq; Overflow = ov;
        cyc = 0; n_pc = 0; n_reg = 0; n_mem = 0; n_mdr = 0; n_epc = 0; cause = 0; lpcs = 0; wb = 0;
        n_fetch = 0; n_memrd = 0; mdr_at = -1; bad_addr = 0; done = 0;
        for (int k = 0; k < 60; k++) begin
            if (seen && o.st == 4'(S_FETCH)) begin
                done = 1;
                break;
            end
            cyc++;
            if (o.st == 4'(S_FETCH)) n_fetch++;
            if (o.st == 4'(S_MEM_RD)) n_memrd++;
            if (o.st == 4'(S_CLOSE)) seen = 1'b1;
            if (o.we[9]) begin n_pc++; lpcs = int'(o.pc_src); end
            if (o.we[6]) begin n_reg++; wb = int'({o.reg_dst, o.data_src}); end
            if (o.we[8]) begin n_mem++; if (!o.addr_src) bad_addr++; end
            if (o.we[3]) begin n_mdr++; mdr_at = n_memrd - 1; if (!o.addr_src) bad_addr++; end
            if (o.we[2]) begin n_epc++; cause = int'(o.cause); end
            @(negedge clk);
        end
        chk("instr_done", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int found;
        //            op         fn         eq    ov    cyc pc rg mem mdr epc cause lpcs wb
        tv[0]  = '{6'b000000, 6'b100000, 1'b0, 1'b0, 8,  1, 1, 0, 0, 0, 0, 0, 8};
        tv[1]  = '{6'b000000, 6'b100010, 1'b0, 1'b1, 9,  2, 0, 0, 0, 1, 0, 3, 0};
        tv[2]  = '{6'b000000, 6'b100100, 1'b0, 1'b1, 8,  1, 1, 0, 0, 0, 0, 0, 8};
        tv[3]  = '{6'b000000, 6'b000000, 1'b0, 1'b0, 8,  2, 0, 0, 0, 1, 1, 3, 0};
        tv[4]  = '{6'b001000, 6'b000000, 1'b0, 1'b0, 8,  1, 1, 0, 0, 0, 0, 0, 0};
        tv[5]  = '{6'b001000, 6'b000000, 1'b0, 1'b1, 9,  2, 0, 0, 0, 1, 0, 3, 0};
        tv[6]  = '{6'b100011, 6'b000000, 1'b0, 1'b0, 11, 1, 1, 0, 1, 0, 0, 0, 1};
        tv[7]  = '{6'b101011, 6'b000000, 1'b0, 1'b0, 8,  1, 0, 1, 0, 0, 0, 0, 0};
        tv[8]  = '{6'b000100, 6'b000000, 1'b1, 1'b0, 7,  2, 0, 0, 0, 0, 0, 1, 0};
        tv[9]  = '{6'b000100, 6'b000000, 1'b0, 1'b0, 7,  1, 0, 0, 0, 0, 0, 0, 0};
        tv[10] = '{6'b000101, 6'b000000, 1'b1, 1'b0, 7,  1, 0, 0, 0, 0, 0, 0, 0};
        tv[11] = '{6'b000101, 6'b000000, 1'b0, 1'b0, 7,  2, 0, 0, 0, 0, 0, 1, 0};
        tv[12] = '{6'b000010, 6'b000000, 1'b0, 1'b0, 7,  2, 0, 0, 0, 0, 0, 2, 0};
        tv[13] = '{6'b111111, 6'b000000, 1'b0, 1'b0, 8,  2, 0, 0, 0, 1, 1, 3, 0};

        sel = 0;
        opcode = 6'b000000; funct = 6'b100000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", int'(o.st), S_RESET);
        chk("reset_rst_out", int'(o.rst_out), 1);
        chk("reset_we", int'(o.we), 0);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("add_c%0d_state", c + 1), int'(o.st), exp_st[c]);
            chk($sformatf("add_c%0d_we", c + 1), int'(o.we), exp_we[c]);
            if (c == 0) chk("add_c1_rst_out", int'(o.rst_out), 1);
            if (c == 7) chk("add_c8_reg_dst", int'(o.reg_dst), 1);
            if (c < 9) @(negedge clk);
        end

        foreach (tv[i]) begin
            run(tv[i].op, tv[i].fn, tv[i].eq, tv[i].ov);
            chk($sformatf("v%0d_cycles", i), cyc, tv[i].cyc);
            chk($sformatf("v%0d_pc_w", i), n_pc, tv[i].pc);
            chk($sformatf("v%0d_reg_w", i), n_reg, tv[i].rg);
            chk($sformatf("v%0d_mem_w", i), n_mem, tv[i].mem);
            chk($sformatf("v%0d_mdr_w", i), n_mdr, tv[i].mdr);
            chk($sformatf("v%0d_epc_w", i), n_epc, tv[i].epc);
            chk($sformatf("v%0d_exc_cause", i), cause, tv[i].cause);
            chk($sformatf("v%0d_last_pc_src", i), lpcs, tv[i].lpcs);
            chk($sformatf("v%0d_wb_sel", i), wb, tv[i].wb);
            chk($sformatf("v%0d_mem_addr_src", i), bad_addr, 0);
        end

        // Abort a lw in its second MEM_RD cycle.
        opcode = 6'b100011; funct = 6'b000000; EQ = 1'b0; Overflow = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (o.st == 4'(S_MEM_RD)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_memrd_reached", found, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_state", int'(o.st), S_RESET);
        chk("abort_we", int'(o.we), 0);
        chk("abort_rst_out", int'(o.rst_out), 1);
        reset = 1'b1;

        sel = 1;
        pulse_reset();
        run(6'b100011, 6'b000000, 1'b0, 1'b0);
        chk("mw4_lw_cycles", cyc, 15);
        chk("mw4_fetch_len", n_fetch, 5);
        chk("mw4_memrd_len", n_memrd, 5);
        chk("mw4_mdr_count", n_mdr, 1);
        chk("mw4_mdr_pos", mdr_at, 4);
        chk("mw4_reg_w", n_reg, 1);
        chk("mw4_wb_sel", wb, 1);
        chk("mw4_mem_addr_src", bad_addr, 0);

        sel = 2;
        pulse_reset();
        run(6'b000000, 6'b100000, 1'b0, 1'b1);
        chk("noexc_ovf_cycles", cyc, 8);
        chk("noexc_ovf_reg_w", n_reg, 1);
        chk("noexc_ovf_epc_w", n_epc, 0);
        chk("noexc_ovf_pc_w", n_pc, 1);
        run(6'b111111, 6'b000000, 1'b0, 1'b0);
        chk("noexc_badop_cycles", cyc, 6);
        chk("noexc_badop_pc_w", n_pc, 1);
        chk("noexc_badop_epc_w", n_epc, 0);
        chk("noexc_badop_reg_w", n_reg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
